inst_seq_gen: RTL and testbench

Parametrised 6502 instruction-cycle sequencer, successor to the fixed 6-state one-hot timing generator. Produces a one-hot T-state vector, a matching binary cycle number and the registered SYNC (opcode-fetch) strobe for the decode/microcode logic. Adds a RDY stall, detection of a runaway past the last T-state, and IRQ/NMI capture that marks whether the next instruction slot becomes an interrupt sequence. Sits between the decode ROM (which drives `next_sync`) and the datapath control.

---
 rtl/inst_seq_pkg.sv | 15 +
 rtl/int_capture.sv | 52 +++++
 rtl/inst_seq_gen.sv | 113 +++++++++++
 tb/tb_inst_seq_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_seq_pkg.sv
// Shared definitions for the 6502 instruction-cycle sequencer.
//   MAX_CYCLES_DEF : default number of T-states
//   T0_ONEHOT      : one-hot value of T0 (bit 0 set), cast to the vector width at use
//   int_kind_e     : encoding of int_nmi (INT_IRQ = IRQ vector, INT_NMI = NMI vector)
package inst_seq_pkg;

  localparam int unsigned MAX_CYCLES_DEF = 8;
  localparam int unsigned T0_ONEHOT      = 1;

  typedef enum logic {
    INT_IRQ = 1'b0,
    INT_NMI = 1'b1
  } int_kind_e;

endpackage

// File: rtl/int_capture.sv
// NMI falling-edge capture, NMI pending latch and IRQ/NMI arbitration.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   accept     : rdy & next_sync, the cycle that starts a new instruction slot
//   nmi_n      : NMI request, active low, falling-edge sensitive
//   irq_n      : IRQ request level, active low
//   irq_mask   : P.I flag, masks IRQ while high
//   take_int   : the new slot is an interrupt sequence (valid with accept)
//   take_nmi   : the new slot services NMI (valid with accept)
module int_capture (
  input  logic clk,
  input  logic rst_n,
  input  logic accept,
  input  logic nmi_n,
  input  logic irq_n,
  input  logic irq_mask,
  output logic take_int,
  output logic take_nmi
);

  logic nmi_prev_q, nmi_prev_d;
  logic nmi_pend_q, nmi_pend_d;
  logic nmi_fell;

  // Edge register runs every cycle, independent of rdy.
  assign nmi_fell = nmi_prev_q & ~nmi_n;

  assign take_nmi = accept & nmi_pend_q;
  assign take_int = accept & (nmi_pend_q | (~irq_n & ~irq_mask));

  always_comb begin
    nmi_prev_d = nmi_n;
    nmi_pend_d = nmi_pend_q;
    // A new edge wins over consumption so a second NMI is not lost.
    if (nmi_fell) begin
      nmi_pend_d = 1'b1;
    end else if (take_nmi) begin
      nmi_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nmi_prev_q <= 1'b1;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_prev_q <= nmi_prev_d;
      nmi_pend_q <= nmi_pend_d;
    end
  end

endmodule

// File: rtl/inst_seq_gen.sv
// 6502 instruction-cycle sequencer: one-hot T-state, binary cycle number,
// registered SYNC strobe, RDY stall, overrun detection and interrupt slot marking.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   next_sync   : current cycle is the last of the instruction
//   rdy         : 1 = advance, 0 = freeze sequencer state
//   irq_n       : IRQ level request, active low
//   irq_mask    : P.I flag
//   nmi_n       : NMI request, active low, falling edge
//   cycle       : one-hot T-state, bit 0 = T0
//   cycle_num   : binary index of the set cycle bit
//   sync        : high during opcode fetch (T0)
//   int_active  : current slot is an interrupt sequence
//   int_nmi     : with int_active, 1 = NMI vector, 0 = IRQ vector
//   overrun     : sticky, sequencer tried to advance past the last T-state
module inst_seq_gen
  import inst_seq_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int unsigned CW         = $clog2(MAX_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  next_sync,
  input  logic                  rdy,
  input  logic                  irq_n,
  input  logic                  irq_mask,
  input  logic                  nmi_n,
  output logic [MAX_CYCLES-1:0] cycle,
  output logic [CW-1:0]         cycle_num,
  output logic                  sync,
  output logic                  int_active,
  output logic                  int_nmi,
  output logic                  overrun
);

  logic [MAX_CYCLES-1:0] cycle_q, cycle_d;
  logic [CW-1:0]         cycle_num_q, cycle_num_d;
  logic                  sync_q, sync_d;
  logic                  int_active_q, int_active_d;
  int_kind_e             int_nmi_q, int_nmi_d;
  logic                  overrun_q, overrun_d;

  logic accept;
  logic take_int;
  logic take_nmi;

  assign accept = rdy & next_sync;

  int_capture u_int_capture (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept   (accept),
    .nmi_n    (nmi_n),
    .irq_n    (irq_n),
    .irq_mask (irq_mask),
    .take_int (take_int),
    .take_nmi (take_nmi)
  );

  always_comb begin
    cycle_d      = cycle_q;
    cycle_num_d  = cycle_num_q;
    sync_d       = sync_q;
    int_active_d = int_active_q;
    int_nmi_d    = int_nmi_q;
    overrun_d    = overrun_q;
    if (rdy) begin
      if (next_sync) begin
        cycle_d      = MAX_CYCLES'(T0_ONEHOT);
        cycle_num_d  = '0;
        sync_d       = 1'b1;
        int_active_d = take_int;
        int_nmi_d    = take_nmi ? INT_NMI : INT_IRQ;
      end else begin
        sync_d = 1'b0;
        // Saturate at the last T-state instead of wrapping; flag the runaway.
        if (cycle_q[MAX_CYCLES-1]) begin
          overrun_d = 1'b1;
        end else begin
          cycle_d     = {cycle_q[MAX_CYCLES-2:0], 1'b0};
          cycle_num_d = cycle_num_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q      <= MAX_CYCLES'(T0_ONEHOT);
      cycle_num_q  <= '0;
      sync_q       <= 1'b1;
      int_active_q <= 1'b0;
      int_nmi_q    <= INT_IRQ;
      overrun_q    <= 1'b0;
    end else begin
      cycle_q      <= cycle_d;
      cycle_num_q  <= cycle_num_d;
      sync_q       <= sync_d;
      int_active_q <= int_active_d;
      int_nmi_q    <= int_nmi_d;
      overrun_q    <= overrun_d;
    end
  end

  assign cycle      = cycle_q;
  assign cycle_num  = cycle_num_q;
  assign sync       = sync_q;
  assign int_active = int_active_q;
  assign int_nmi    = int_nmi_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_inst_seq_gen.sv
// Self-checking bench for inst_seq_gen (MAX_CYCLES = 8).
module tb_inst_seq_gen;

  localparam int MC = 8;
  localparam int CWB = 3;

  logic           clk = 1'b0;
  logic           rst_n, next_sync, rdy, irq_n, irq_mask, nmi_n;
  logic [MC-1:0]  cycle;
  logic [CWB-1:0] cycle_num;
  logic           sync, int_active, int_nmi, overrun;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model state
  int m_t;
  bit m_sync, m_ia, m_in, m_ov, m_pend, m_prev;

  inst_seq_gen #(.MAX_CYCLES(MC), .CW(CWB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_sync  (next_sync),
    .rdy        (rdy),
    .irq_n      (irq_n),
    .irq_mask   (irq_mask),
    .nmi_n      (nmi_n),
    .cycle      (cycle),
    .cycle_num  (cycle_num),
    .sync       (sync),
    .int_active (int_active),
    .int_nmi    (int_nmi),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: T-state index with saturation, interrupt choice at each accepted slot start.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_t = 0; m_sync = 1; m_ia = 0; m_in = 0; m_ov = 0; m_pend = 0; m_prev = 1;
    end else begin
      bit fell, consume;
      fell = m_prev && !nmi_n;
      consume = 0;
      if (rdy) begin
        if (next_sync) begin
          m_t = 0; m_sync = 1;
          if (m_pend) begin m_ia = 1; m_in = 1; consume = 1; end
          else if (!irq_n && !irq_mask) begin m_ia = 1; m_in = 0; end
          else begin m_ia = 0; m_in = 0; end
        end else begin
          m_sync = 0;
          if (m_t == MC - 1) m_ov = 1;
          else m_t = m_t + 1;
        end
      end
      if (fell) m_pend = 1;
      else if (consume) m_pend = 0;
      m_prev = nmi_n;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle", 32'(cycle), 32'(1 << m_t));
      check("cycle_num", 32'(cycle_num), 32'(m_t));
      check("onehot", 32'($onehot(cycle)), 32'd1);
      check("sync", 32'(sync), 32'(m_sync));
      check("int_active", 32'(int_active), 32'(m_ia));
      if (m_ia) check("int_nmi", 32'(int_nmi), 32'(m_in));
      check("overrun", 32'(overrun), 32'(m_ov));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic ns, input logic r, input logic in_, input logic mk, input logic nn);
    next_sync = ns; rdy = r; irq_n = in_; irq_mask = mk; nmi_n = nn;
    cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr_tab [3];
    fr_tab[0] = 8'h02; fr_tab[1] = 8'h04; fr_tab[2] = 8'h01;
    rst_n = 1'b0; next_sync = 1'b0; rdy = 1'b1; irq_n = 1'b1; irq_mask = 1'b1; nmi_n = 1'b1;
    cyc();
    chk_en = 1'b1;
    do_reset();
    check("rst_cycle", 32'(cycle), 32'h01);
    check("rst_num", 32'(cycle_num), 32'd0);
    check("rst_sync", 32'(sync), 32'd1);
    check("rst_int_active", 32'(int_active), 32'd0);
    check("rst_int_nmi", 32'(int_nmi), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Free run, next_sync every third cycle
    for (int k = 0; k < 6; k++) begin
      step((k % 3) == 2, 1'b1, 1'b1, 1'b1, 1'b1);
      check("fr_cycle", 32'(cycle), 32'(fr_tab[k % 3]));
      check("fr_sync", 32'(sync), 32'((k % 3) == 2));
    end

    // Stall at T2 for 4 cycles, NMI edge inside the stall
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("pre_stall_cycle", 32'(cycle), 32'h04);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, (k >= 1) ? 1'b0 : 1'b1);
      check("stall_cycle", 32'(cycle), 32'h04);
      check("stall_num", 32'(cycle_num), 32'd2);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("post_stall_cycle", 32'(cycle), 32'h08);
    check("post_stall_num", 32'(cycle_num), 32'd3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("stall_nmi_active", 32'(int_active), 32'd1);
    check("stall_nmi_kind", 32'(int_nmi), 32'd1);
    // nmi_n held low: no second NMI, back-to-back slot
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("held_nmi_active", 32'(int_active), 32'd0);
    check("b2b_sync", 32'(sync), 32'd1);

    // IRQ masking
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("irq_masked", 32'(int_active), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("irq_taken", 32'(int_active), 32'd1);
    check("irq_kind", 32'(int_nmi), 32'd0);

    // NMI priority over unmasked IRQ, then held nmi_n lets IRQ through
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("nmi_prio_active", 32'(int_active), 32'd1);
    check("nmi_prio_kind", 32'(int_nmi), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("after_nmi_irq_active", 32'(int_active), 32'd1);
    check("after_nmi_irq_kind", 32'(int_nmi), 32'd0);

    // New NMI edge in the consuming cycle stays pending
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("nmi_consume_kind", 32'(int_nmi), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("nmi_second_active", 32'(int_active), 32'd1);
    check("nmi_second_kind", 32'(int_nmi), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("nmi_third_active", 32'(int_active), 32'd0);

    // Overrun
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      if (i == 7) check("ovr_last_state_flag", 32'(overrun), 32'd0);
      if (i == 8) check("ovr_set", 32'(overrun), 32'd1);
    end
    check("ovr_sat_cycle", 32'(cycle), 32'h80);
    check("ovr_sat_num", 32'(cycle_num), 32'd7);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("ovr_sticky", 32'(overrun), 32'd1);
    check("ovr_new_slot", 32'(cycle), 32'h01);

    // Reset at T5 with NMI pending
    do_reset();
    check("ovr_cleared", 32'(overrun), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("t5_cycle", 32'(cycle), 32'h20);
    rst_n = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
    check("mid_rst_cycle", 32'(cycle), 32'h01);
    check("mid_rst_sync", 32'(sync), 32'd1);
    check("mid_rst_int", 32'(int_active), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("mid_rst_pend_cleared", 32'(int_active), 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
